oled_screen_driver: RTL and testbench

Single-clock SSD1306-style 128x64 OLED driver: runs the panel power-up/reset sequence, streams a fixed initialization command list over a 4-wire write-only SPI link, then refreshes the display continuously from an external 1024-byte frame source. It sits below the SPI-slave top level, which supplies `pixelData` for each `pixelAddress` it requests.

---
 rtl/oled_screen_driver_if.sv | 21 ++
 rtl/oled_screen_driver.sv | 146 ++++++++++++++
 tb/tb_oled_screen_driver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/oled_screen_driver_if.sv
// Panel-side SPI pins plus the frame-source address/data pair of the OLED driver.
// The driver owns the master modport; the panel/frame-source side owns the slave modport.
interface oled_screen_driver_if;
  logic       ioSclk;
  logic       ioSdin;
  logic       ioCs;
  logic       ioDc;
  logic       ioReset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;

  modport master (
    output ioSclk, ioSdin, ioCs, ioDc, ioReset, pixelAddress,
    input  pixelData
  );

  modport slave (
    input  ioSclk, ioSdin, ioCs, ioDc, ioReset, pixelAddress,
    output pixelData
  );
endinterface

// File: rtl/oled_screen_driver.sv
// SSD1306-style 128x64 OLED driver: power-up, 23-byte init list, then endless 1024-byte refresh over SPI.
// Init byte 18 cycles, data byte 17 cycles; no backpressure, the frame source answers one cycle after each address.
module oled_screen_driver #(
  parameter int unsigned STARTUP_WAIT = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst_btn,
  oled_screen_driver_if.master bus
);

  typedef enum logic [2:0] {
    INIT_POWER,
    LOAD_INIT_CMD,
    SEND,
    CHECK_FINISHED_INIT,
    LOAD_DATA
  } state_t;

  localparam logic [31:0] W      = 32'(STARTUP_WAIT);
  localparam logic [31:0] W2     = 2 * W;
  localparam logic [31:0] W3     = 3 * W;
  localparam logic [4:0]  N_CMDS = 5'd23;

  state_t      r_state;
  state_t      r_ret;
  logic [31:0] r_cnt;
  logic [4:0]  r_cmd_idx;
  logic [2:0]  r_bit;
  logic        r_phase;
  logic [7:0]  r_byte;
  logic        r_sclk;
  logic        r_sdin;
  logic        r_cs;
  logic        r_dc;
  logic        r_reset;
  logic [9:0]  r_addr;

  logic [31:0] w_cnt_next;
  logic [7:0]  w_cmd;

  assign w_cnt_next = r_cnt + 32'd1;

  always_comb begin
    w_cmd = 8'hAE;
    case (r_cmd_idx)
      5'd0:    w_cmd = 8'hAE;
      5'd1:    w_cmd = 8'h81;
      5'd2:    w_cmd = 8'h7F;
      5'd3:    w_cmd = 8'hA6;
      5'd4:    w_cmd = 8'h20;
      5'd5:    w_cmd = 8'h00;
      5'd6:    w_cmd = 8'hC8;
      5'd7:    w_cmd = 8'hA1;
      5'd8:    w_cmd = 8'h40;
      5'd9:    w_cmd = 8'hA8;
      5'd10:   w_cmd = 8'h3F;
      5'd11:   w_cmd = 8'hD3;
      5'd12:   w_cmd = 8'h00;
      5'd13:   w_cmd = 8'hD5;
      5'd14:   w_cmd = 8'h80;
      5'd15:   w_cmd = 8'hD9;
      5'd16:   w_cmd = 8'h22;
      5'd17:   w_cmd = 8'hDB;
      5'd18:   w_cmd = 8'h20;
      5'd19:   w_cmd = 8'h8D;
      5'd20:   w_cmd = 8'h14;
      5'd21:   w_cmd = 8'hA4;
      5'd22:   w_cmd = 8'hAF;
      default: w_cmd = 8'hAE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_state   <= INIT_POWER;
      r_ret     <= INIT_POWER;
      r_cnt     <= '0;
      r_cmd_idx <= '0;
      r_bit     <= '0;
      r_phase   <= 1'b0;
      r_byte    <= '0;
      r_sclk    <= 1'b1;
      r_sdin    <= 1'b0;
      r_cs      <= 1'b1;
      r_dc      <= 1'b0;
      r_reset   <= 1'b1;
      r_addr    <= '0;
    end else begin
      case (r_state)
        INIT_POWER: begin
          // ioReset tracks the count the counter is about to hold, so it is registered in step with it
          r_reset <= !((w_cnt_next >= W) && (w_cnt_next < W2));
          if (w_cnt_next == W3) begin
            r_cnt   <= '0;
            r_state <= LOAD_INIT_CMD;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        LOAD_INIT_CMD: begin
          r_cs      <= 1'b0;
          r_dc      <= 1'b0;
          r_byte    <= w_cmd;
          r_bit     <= 3'd7;
          r_cmd_idx <= r_cmd_idx + 5'd1;
          r_ret     <= CHECK_FINISHED_INIT;
          r_state   <= SEND;
        end
        SEND: begin
          if (!r_phase) begin
            r_sclk  <= 1'b0;
            r_sdin  <= r_byte[r_bit];
            r_phase <= 1'b1;
          end else begin
            r_sclk  <= 1'b1;
            r_phase <= 1'b0;
            if (r_bit == 3'd0) r_state <= r_ret;
            else               r_bit   <= r_bit - 3'd1;
          end
        end
        CHECK_FINISHED_INIT: begin
          r_state <= (r_cmd_idx == N_CMDS) ? LOAD_DATA : LOAD_INIT_CMD;
        end
        LOAD_DATA: begin
          // pixelData here belongs to r_addr, which has been stable for the whole previous byte
          r_cs    <= 1'b0;
          r_dc    <= 1'b1;
          r_byte  <= bus.pixelData;
          r_bit   <= 3'd7;
          r_ret   <= LOAD_DATA;
          r_state <= SEND;
          r_addr  <= r_addr + 10'd1;
        end
        default: r_state <= INIT_POWER;
      endcase
    end
  end

  assign bus.ioSclk       = r_sclk;
  assign bus.ioSdin       = r_sdin;
  assign bus.ioCs         = r_cs;
  assign bus.ioDc         = r_dc;
  assign bus.ioReset      = r_reset;
  assign bus.pixelAddress = r_addr;

endmodule

// File: tb/tb_oled_screen_driver.sv
// Bench for oled_screen_driver: decodes the SPI stream at SCLK rising edges and compares it with the
// expected command list and an address-derived frame pattern, including frame wrap and mid-byte reset.
module tb_oled_screen_driver;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_btn = 1'b0;
  logic [7:0] key = 8'h5A;

  oled_screen_driver_if bus ();

  oled_screen_driver #(.STARTUP_WAIT(W)) dut (
    .clk     (clk),
    .rst_btn (rst_btn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // frame source with one cycle of registered latency
  always @(posedge clk) bus.pixelData <= bus.pixelAddress[7:0] ^ key;

  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  logic prev_sclk = 1'b1;

  logic [7:0] init_cmds [23] = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'hC8, 8'hA1,
                                 8'h40, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'hD5, 8'h80, 8'hD9,
                                 8'h22, 8'hDB, 8'h20, 8'h8D, 8'h14, 8'hA4, 8'hAF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Collect 8 bits sampled on SCLK rising edges; reports ioDc, whether it moved, and the first-fall cycle.
  task automatic get_byte(output logic [7:0] b, output logic dc, output logic dc_moved,
                          output int fall_cyc, output logic timeout);
    int nb = 0;
    int budget = 0;
    b = 8'h00;
    dc = 1'b0;
    dc_moved = 1'b0;
    fall_cyc = -1;
    timeout = 1'b0;
    while (nb < 8 && !timeout) begin
      step();
      budget++;
      if (budget > 200) timeout = 1'b1;
      if (prev_sclk && !bus.ioSclk && fall_cyc < 0) fall_cyc = cyc;
      if (!prev_sclk && bus.ioSclk) begin
        b = {b[6:0], bus.ioSdin};
        if (nb == 0) dc = bus.ioDc;
        else if (bus.ioDc !== dc) dc_moved = 1'b1;
        nb++;
      end
      prev_sclk = bus.ioSclk;
    end
  endtask

  task automatic power_up();
    @(negedge clk);
    rst_btn = 1'b1;
    cyc = 0;
    prev_sclk = 1'b1;
    #1;
    chk("ioReset_cycle0", 32'(bus.ioReset), 32'd1);
    for (int k = 1; k <= 3 * W + 1; k++) begin
      step();
      chk("ioReset_powerup", 32'(bus.ioReset), (k >= W && k < 2 * W) ? 32'd0 : 32'd1);
      chk("ioCs_powerup", 32'(bus.ioCs), (k >= 3 * W + 1) ? 32'd0 : 32'd1);
    end
    prev_sclk = bus.ioSclk;
  endtask

  task automatic init_seq();
    logic [7:0] b;
    logic dc, moved, to;
    int fc;
    int prev_fc = 0;
    for (int i = 0; i < 23; i++) begin
      get_byte(b, dc, moved, fc, to);
      chk("init_timeout", 32'(to), 32'd0);
      chk("init_byte", 32'(b), 32'(init_cmds[i]));
      chk("init_dc", 32'(dc), 32'd0);
      chk("init_dc_stable", 32'(moved), 32'd0);
      if (i == 0) chk("first_sclk_fall", 32'(fc), 32'(3 * W + 2));
      else        chk("init_spacing", 32'(fc - prev_fc), 32'd18);
      prev_fc = fc;
    end
  endtask

  task automatic data_seq(input int n);
    logic [7:0] b;
    logic dc, moved, to;
    int fc;
    int prev_fc = 0;
    for (int i = 0; i < n; i++) begin
      get_byte(b, dc, moved, fc, to);
      chk("data_timeout", 32'(to), 32'd0);
      chk("data_byte", 32'(b), 32'(((i % 1024) & 255) ^ int'(key)));
      chk("data_dc", 32'(dc), 32'd1);
      chk("data_dc_stable", 32'(moved), 32'd0);
      chk("next_address", 32'(bus.pixelAddress), 32'((i + 1) % 1024));
      if (i > 0) chk("data_spacing", 32'(fc - prev_fc), 32'd17);
      prev_fc = fc;
    end
  endtask

  initial begin
    rst_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ioSclk", 32'(bus.ioSclk), 32'd1);
    chk("rst_ioSdin", 32'(bus.ioSdin), 32'd0);
    chk("rst_ioCs", 32'(bus.ioCs), 32'd1);
    chk("rst_ioDc", 32'(bus.ioDc), 32'd0);
    chk("rst_ioReset", 32'(bus.ioReset), 32'd1);
    chk("rst_pixelAddress", 32'(bus.pixelAddress), 32'd0);

    power_up();
    init_seq();
    data_seq(1030);

    // reset lands somewhere inside the next data byte
    repeat ($urandom_range(3, 14)) step();
    #1;
    rst_btn = 1'b0;
    #1;
    chk("midrst_ioSclk", 32'(bus.ioSclk), 32'd1);
    chk("midrst_ioSdin", 32'(bus.ioSdin), 32'd0);
    chk("midrst_ioCs", 32'(bus.ioCs), 32'd1);
    chk("midrst_ioDc", 32'(bus.ioDc), 32'd0);
    chk("midrst_ioReset", 32'(bus.ioReset), 32'd1);
    chk("midrst_pixelAddress", 32'(bus.pixelAddress), 32'd0);
    key = 8'($urandom);
    repeat (2) step();
    chk("held_pixelAddress", 32'(bus.pixelAddress), 32'd0);

    power_up();
    init_seq();
    data_seq(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
